native_mem_responder: RTL and testbench
=======================================

Name: native_mem_responder

Overview:
- Synthesizable responder for the CPU core's native memory interface (`mem_valid`/`mem_ready`). It is the target end of the bus the core initiates on.
- Provides word-addressed on-chip RAM plus a memory-mapped console byte port at `CONSOLE_ADDR`, drained through a small FIFO with a valid/ready output.
- Replaces the behavioural memory model so the core can run on FPGA with configurable wait states.

Parameters:
- `MEM_WORDS`, 16384, RAM depth in 32-bit words (power of two).
- `WAIT_STATES`, 1, extra cycles inserted before `mem_ready` (0..15).
- `CONSOLE_ADDR`, 32'h1000_0000, byte address of the console register.
- `FIFO_DEPTH`, 8, console FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  synchronous active-low reset
- `mem_valid`  in  1  request valid; held until `mem_ready` is seen
- `mem_instr`  in  1  instruction fetch flag (informational; no behavioural effect)
- `mem_addr`  in  32  byte address; bits [1:0] ignored
- `mem_wdata`  in  32  write data
- `mem_wstrb`  in  4  byte enables; 0 = read
- `mem_ready`  out  1  one-cycle completion pulse
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1
- `con_valid`  out  1  console byte available (FIFO non-empty)
- `con_data`  out  8  FIFO head byte
- `con_ready`  in  1  consumer accepts byte when `con_valid`&`con_ready`
- `err`  out  1  one-cycle pulse on out-of-range access

Behaviour:
- Reset (`resetn`=0 at posedge):
  - state←IDLE; `mem_ready`, `err`, `con_valid` ←0; `mem_rdata`←0.
  - FIFO pointers and count ←0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE: if `mem_valid`, latch addr/wdata/wstrb; go to WAIT with wcnt←`WAIT_STATES`, or go straight to ACCESS if `WAIT_STATES`=0.
  - WAIT: decrement wcnt; at 1 go to ACCESS.
  - ACCESS: perform the access and assert `mem_ready` (registered) for exactly one cycle, then return to IDLE.
  - Exception: a console write with FIFO full stays in ACCESS, `mem_ready` held 0, until count<`FIFO_DEPTH`.
- Latency:
  - With `mem_valid` first high in cycle N, `mem_ready` is high in cycle N+2+`WAIT_STATES` (N+2 when `WAIT_STATES`=0).
  - The initiator drops or changes `mem_valid` after the ready cycle. The responder samples a new request in IDLE only, so back-to-back requests have one IDLE cycle minimum.
  - Request signals change while pending → undefined (latched copy is used).
- RAM region:
  - addr[31:2] < `MEM_WORDS`: index = addr[31:2].
  - Write: per-byte merge by `wstrb`.
  - Read: `mem_rdata` = word at index.
- Console (addr[31:2] == `CONSOLE_ADDR`[31:2]):
  - Write with `wstrb`[0]=1 pushes `wdata`[7:0].
  - Write with `wstrb`[0]=0 completes with no push.
  - Read returns {24'b0, 8-bit FIFO count}.
- Any other address:
  - Read returns 0; write is dropped.
  - `err` pulses in the same cycle as `mem_ready`; completion is not stalled.
- FIFO:
  - Push and pop in the same cycle leave count unchanged.
  - The full check uses the registered count, so a push waiting on full completes in the cycle after the pop that frees space.
  - `con_data` is stable while `con_valid`=1 and `con_ready`=0.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Reset mid-transaction:
  - The pending request is abandoned with no `mem_ready`.
  - A write already performed in ACCESS persists.
  - FIFO bytes are discarded.

Test Plan:
- `WAIT_STATES`=1: write 32'hDEADBEEF to 0x100 with `wstrb`=4'hF, then read 0x100 → each `mem_ready` arrives 3 cycles after `mem_valid` rises; read returns 32'hDEADBEEF.
- Byte strobe: write 32'h11223344 to 0x200, then write 32'hAABBCCDD with `wstrb`=4'b0100 → read returns 32'h11BB3344.
- Console: `con_ready`=0, write 'H','i' to 0x1000_0000 → reading 0x1000_0000 returns 2; set `con_ready`=1 → `con_data` emits 8'h48 then 8'h69, and `con_valid` falls.
- FIFO full stall: `con_ready`=0, write 9 bytes with `FIFO_DEPTH`=8 → 9th request has no `mem_ready`; one-cycle `con_ready` pulse → 9th `mem_ready` follows one cycle after the pop; count stays 8.
- Out of range: read 0x2000_0000 → `mem_rdata`=0 and `err`=1 coincident with `mem_ready`; write there leaves RAM unchanged.
- Reset in WAIT: assert `resetn`=0 for one cycle with `WAIT_STATES`=3 mid-request → no `mem_ready`, FIFO empty, earlier RAM data still readable.

Source files
------------

// File: rtl/native_mem_responder.sv
// Target end of the core's native mem_valid/mem_ready bus: word RAM with byte strobes,
// a console byte port drained through a small FIFO, and configurable wait states.
module native_mem_responder #(
    parameter int          MEM_WORDS    = 16384,
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [29:0]   RAM_LIMIT = 30'(MEM_WORDS);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [3:0]    WS_INIT   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    state_t        r_state, w_state_next;
    logic [3:0]    r_wcnt, w_wcnt_next;
    logic          w_latch;

    logic [29:0]   r_word;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;

    logic          r_mem_ready, r_err, r_rd_sel_ram;
    logic [31:0]   r_rdata_misc;

    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;

    logic          w_is_con, w_is_ram, w_is_write;
    logic          w_con_push, w_stall, w_do_access;
    logic          w_push, w_pop, w_ram_we, w_ram_re;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_ram_rdata;
    logic          w_unused;

    assign w_unused = &{1'b0, mem_instr, mem_addr[1:0]};

    // Decode from the latched request so mid-transaction input changes are ignored.
    assign w_is_con   = (r_word == CONSOLE_ADDR[31:2]);
    assign w_is_ram   = !w_is_con && (r_word < RAM_LIMIT);
    assign w_is_write = (r_wstrb != 4'h0);
    assign w_ram_idx  = r_word[AW-1:0];

    assign w_con_push  = (r_state == S_ACCESS) && w_is_con && r_wstrb[0];
    assign w_stall     = w_con_push && (r_count == FIFO_FULL);
    assign w_do_access = resetn && (r_state == S_ACCESS) && !w_stall;
    assign w_push      = w_do_access && w_con_push;
    assign w_pop       = con_valid && con_ready;
    assign w_ram_we    = w_do_access && w_is_ram && w_is_write;
    assign w_ram_re    = w_do_access && w_is_ram && !w_is_write;

    always_comb begin
        w_state_next = r_state;
        w_wcnt_next  = r_wcnt;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The ready cycle still shows the old request's mem_valid; skip it.
                if (mem_valid && !r_mem_ready) begin
                    w_latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_next = S_ACCESS;
                    end else begin
                        w_state_next = S_WAIT;
                        w_wcnt_next  = WS_INIT;
                    end
                end
            end
            S_WAIT: begin
                w_wcnt_next = r_wcnt - 1'b1;
                if (r_wcnt <= 4'd1) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!w_stall) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_wcnt       <= 4'd0;
            r_mem_ready  <= 1'b0;
            r_err        <= 1'b0;
            r_rd_sel_ram <= 1'b0;
            r_rdata_misc <= 32'h0;
        end else begin
            r_state     <= w_state_next;
            r_wcnt      <= w_wcnt_next;
            r_mem_ready <= w_do_access;
            r_err       <= w_do_access && !w_is_con && !w_is_ram;
            if (w_do_access) begin
                r_rd_sel_ram <= w_is_ram && !w_is_write;
                r_rdata_misc <= (w_is_con && !w_is_write) ? 32'(r_count) : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_word  <= mem_addr[31:2];
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
        end
    end

    // One RAM per byte lane keeps the strobed write a plain single-port template.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_ram [MEM_WORDS];
        logic [7:0] r_rd;

        always_ff @(posedge clk) begin
            if (w_ram_we && r_wstrb[gi]) begin
                r_ram[w_ram_idx] <= r_wdata[gi*8 +: 8];
            end
            if (w_ram_re) begin
                r_rd <= r_ram[w_ram_idx];
            end
        end

        assign w_ram_rdata[gi*8 +: 8] = r_rd;
    end

    assign mem_ready = r_mem_ready;
    assign err       = r_err;
    assign mem_rdata = r_rd_sel_ram ? w_ram_rdata : r_rdata_misc;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= r_wdata[7:0];
        end
    end

    assign con_valid = (r_count != '0);
    assign con_data  = r_fifo[r_rptr];

endmodule

// File: tb/tb_native_mem_responder.sv
// Randomized bench for native_mem_responder: a transaction-level model predicts every
// cycle's outputs; directed steps pin latency, strobes, console FIFO, errors and reset.
module tb_native_mem_responder;
    localparam int          WS       = 1;
    localparam int          MEMW     = 1024;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] CON      = 32'h1000_0000;
    localparam logic [29:0] CON_WORD = 30'h0400_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, mem_valid, mem_instr, mem_ready, con_valid, con_ready, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [7:0]  con_data;

    logic        resetn3, v3, i3, rdy3, cv3, cr3, e3;
    logic [31:0] a3, wd3, rd3;
    logic [3:0]  ws3;
    logic [7:0]  cd3;

    native_mem_responder #(.MEM_WORDS(MEMW), .WAIT_STATES(WS), .CONSOLE_ADDR(CON), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .con_valid(con_valid),
        .con_data(con_data), .con_ready(con_ready), .err(err)
    );

    native_mem_responder #(.MEM_WORDS(MEMW), .WAIT_STATES(3), .CONSOLE_ADDR(CON), .FIFO_DEPTH(DEPTH)) u_dut3 (
        .clk(clk), .resetn(resetn3), .mem_valid(v3), .mem_instr(i3),
        .mem_addr(a3), .mem_wdata(wd3), .mem_wstrb(ws3),
        .mem_ready(rdy3), .mem_rdata(rd3), .con_valid(cv3),
        .con_data(cd3), .con_ready(cr3), .err(e3)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Console consumer: directed value or random handshake, applied after the request drive.
    bit   rand_con = 1'b0;
    logic con_cmd  = 1'b0;
    initial begin
        con_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            con_ready = rand_con ? 1'($urandom_range(0, 1)) : con_cmd;
        end
    end

    // Transaction-level model: a request seen while idle completes WS+2 cycles later,
    // unless it is a console push against a full queue.
    bit          model_on = 1'b0;
    bit          busy = 1'b0;
    int          acc_cyc = 0;
    int          cyc = 0;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        exp_ready = 1'b0, exp_err = 1'b0, exp_rd_valid = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic [7:0]  q[$];
    logic [31:0] m_mem [int];
    int          m_size0;
    bit          m_pop, m_push, m_ready_n, m_err_n, m_is_con, m_is_ram, m_is_wr;
    logic [7:0]  m_pv;
    logic [29:0] m_word;
    logic [31:0] m_t;

    initial begin : model_proc
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("mem_ready", 32'(mem_ready), 32'(exp_ready));
                check("err", 32'(err), 32'(exp_err));
                if (exp_ready && exp_rd_valid) check("mem_rdata", mem_rdata, exp_rdata);
                check("con_valid", 32'(con_valid), 32'(q.size() != 0));
                if (q.size() != 0) check("con_data", 32'(con_data), 32'(q[0]));
            end
            if (resetn !== 1'b1) begin
                busy = 1'b0;
                q.delete();
                exp_ready = 1'b0;
                exp_err = 1'b0;
                exp_rd_valid = 1'b0;
            end else begin
                m_size0 = q.size();
                m_pop = (m_size0 > 0) && (con_ready === 1'b1);
                m_push = 1'b0;
                m_ready_n = 1'b0;
                m_err_n = 1'b0;
                if (busy && cyc >= acc_cyc + 1 + WS) begin
                    m_word = req_addr[31:2];
                    m_is_con = (m_word == CON_WORD);
                    m_is_ram = !m_is_con && (int'(m_word) < MEMW);
                    m_is_wr = (req_wstrb != 4'h0);
                    if (!(m_is_con && req_wstrb[0] && m_size0 >= DEPTH)) begin
                        m_ready_n = 1'b1;
                        busy = 1'b0;
                        exp_rd_valid = 1'b0;
                        if (m_is_con) begin
                            if (req_wstrb[0]) begin
                                m_push = 1'b1;
                                m_pv = req_wdata[7:0];
                            end
                            if (!m_is_wr) begin
                                exp_rdata = 32'(m_size0);
                                exp_rd_valid = 1'b1;
                            end
                        end else if (m_is_ram) begin
                            if (m_is_wr) begin
                                if (m_mem.exists(int'(m_word))) begin
                                    m_t = m_mem[int'(m_word)];
                                    for (int b = 0; b < 4; b++)
                                        if (req_wstrb[b]) m_t[b*8 +: 8] = req_wdata[b*8 +: 8];
                                    m_mem[int'(m_word)] = m_t;
                                end else if (req_wstrb == 4'hF) begin
                                    m_mem[int'(m_word)] = req_wdata;
                                end
                            end else if (m_mem.exists(int'(m_word))) begin
                                exp_rdata = m_mem[int'(m_word)];
                                exp_rd_valid = 1'b1;
                            end
                        end else begin
                            m_err_n = 1'b1;
                            if (!m_is_wr) begin
                                exp_rdata = 32'h0;
                                exp_rd_valid = 1'b1;
                            end
                        end
                    end
                end else if (!busy && mem_valid === 1'b1 && !exp_ready) begin
                    busy = 1'b1;
                    acc_cyc = cyc;
                    req_addr = mem_addr;
                    req_wdata = mem_wdata;
                    req_wstrb = mem_wstrb;
                end
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back(m_pv);
                exp_ready = m_ready_n;
                exp_err = m_err_n;
            end
            cyc++;
        end
    end

    task automatic do_req(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output logic e, output int lat);
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wd;
        mem_wstrb = st;
        mem_instr = 1'($urandom_range(0, 1));
        lat = -1;
        rd = 32'h0;
        e = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                lat = k;
                rd = mem_rdata;
                e = err;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL req_timeout: no mem_ready for addr %h within 400 cycles", addr);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            mem_wstrb = 4'h0;
        end
    endtask

    task automatic req3(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output int lat);
        @(posedge clk);
        #1;
        v3 = 1'b1;
        a3 = addr;
        wd3 = wd;
        ws3 = st;
        lat = -1;
        rd = 32'h0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rdy3 === 1'b1) begin
                lat = k;
                rd = rd3;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL req3_timeout: no mem_ready for addr %h within 100 cycles", addr);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          widx [17];
    logic [31:0] rd;
    logic        e;
    int          lat, kind;
    logic [31:0] addr;
    logic [3:0]  st;

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        resetn3 = 1'b0; v3 = 1'b0; i3 = 1'b0; a3 = 32'h0; wd3 = 32'h0; ws3 = 4'h0; cr3 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(mem_ready), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_con_valid", 32'(con_valid), 32'd0);
        check("reset_rdata", mem_rdata, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        resetn3 = 1'b1;
        model_on = 1'b1;

        // Latency and full-word write/read
        do_req(32'h100, 32'hDEADBEEF, 4'hF, rd, e, lat);
        check("lat_write", 32'(lat), 32'd3);
        do_req(32'h100, 32'h0, 4'h0, rd, e, lat);
        check("lat_read", 32'(lat), 32'd3);
        check("read_deadbeef", rd, 32'hDEADBEEF);
        idle(1);

        // Byte strobe merge
        do_req(32'h200, 32'h11223344, 4'hF, rd, e, lat);
        do_req(32'h200, 32'hAABBCCDD, 4'b0100, rd, e, lat);
        do_req(32'h200, 32'h0, 4'h0, rd, e, lat);
        check("strobe_merge", rd, 32'h11BB3344);
        idle(1);

        // Console: two bytes, count readback, drain order
        con_cmd = 1'b0;
        do_req(CON, 32'h48, 4'h1, rd, e, lat);
        do_req(CON, 32'h69, 4'h1, rd, e, lat);
        do_req(CON, 32'h0, 4'h0, rd, e, lat);
        check("con_count2", rd, 32'd2);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        con_cmd = 1'b1;
        @(negedge clk);
        check("con_first_valid", 32'(con_valid), 32'd1);
        check("con_first_H", 32'(con_data), 32'h48);
        @(negedge clk);
        check("con_second_i", 32'(con_data), 32'h69);
        @(negedge clk);
        check("con_drained", 32'(con_valid), 32'd0);
        con_cmd = 1'b0;

        // FIFO full stall: ninth push waits for one pop
        for (int i = 0; i < 8; i++) begin
            do_req(CON, 32'hA0 + 32'(i), 4'h1, rd, e, lat);
            check("fill_lat", 32'(lat), 32'd3);
        end
        @(posedge clk);
        #1;
        mem_addr = CON; mem_wdata = 32'hA8; mem_wstrb = 4'h1; mem_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("stall_no_ready", 32'(mem_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        con_cmd = 1'b1;
        @(negedge clk);
        check("stall_pop_cycle", 32'(mem_ready), 32'd0);
        @(posedge clk);
        #1;
        con_cmd = 1'b0;
        @(negedge clk);
        check("stall_push_cycle", 32'(mem_ready), 32'd0);
        @(negedge clk);
        check("stall_release", 32'(mem_ready), 32'd1);
        do_req(CON, 32'h0, 4'h0, rd, e, lat);
        check("stall_count8", rd, 32'd8);
        idle(1);
        con_cmd = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (con_valid === 1'b0) break;
        end
        check("stall_drain_empty", 32'(con_valid), 32'd0);
        con_cmd = 1'b0;

        // Out-of-range accesses and the RAM boundary
        do_req(32'h0, 32'hCAFEF00D, 4'hF, rd, e, lat);
        do_req(32'h2000_0000, 32'h0, 4'h0, rd, e, lat);
        check("oor_read_data", rd, 32'h0);
        check("oor_read_err", 32'(e), 32'd1);
        do_req(32'h2000_0000, 32'hFFFFFFFF, 4'hF, rd, e, lat);
        check("oor_write_err", 32'(e), 32'd1);
        do_req(32'h1000, 32'h0000_1234, 4'hF, rd, e, lat);
        check("first_oor_word_err", 32'(e), 32'd1);
        do_req(32'hFFC, 32'h5A5A5A5A, 4'hF, rd, e, lat);
        check("last_word_no_err", 32'(e), 32'd0);
        do_req(32'hFFC, 32'h0, 4'h0, rd, e, lat);
        check("last_word_read", rd, 32'h5A5A5A5A);
        do_req(32'h0, 32'h0, 4'h0, rd, e, lat);
        check("oor_write_dropped", rd, 32'hCAFEF00D);
        idle(1);

        // Reset during WAIT on the three-wait-state instance
        req3(32'h40, 32'h12345678, 4'hF, rd, lat);
        check("ws3_latency", 32'(lat), 32'd5);
        req3(CON, 32'h55, 4'h1, rd, lat);
        @(posedge clk);
        #1;
        v3 = 1'b0;
        @(negedge clk);
        check("ws3_fifo_before", 32'(cv3), 32'd1);
        check("ws3_fifo_byte", 32'(cd3), 32'h55);
        @(posedge clk);
        #1;
        v3 = 1'b1; a3 = 32'h40; ws3 = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        resetn3 = 1'b0;
        v3 = 1'b0;
        @(posedge clk);
        #1;
        resetn3 = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("ws3_no_ready", 32'(rdy3), 32'd0);
            check("ws3_no_err", 32'(e3), 32'd0);
            check("ws3_fifo_empty", 32'(cv3), 32'd0);
        end
        req3(32'h40, 32'h0, 4'h0, rd, lat);
        check("ws3_ram_kept", rd, 32'h12345678);
        @(posedge clk);
        #1;
        v3 = 1'b0;

        // Randomized traffic against the model
        rand_con = 1'b1;
        for (int i = 0; i < 16; i++) widx[i] = i;
        widx[16] = MEMW - 1;
        for (int i = 0; i < 17; i++) begin
            do_req(32'(widx[i]) << 2, $urandom, 4'hF, rd, e, lat);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5)      addr = (32'(widx[$urandom_range(0, 16)]) << 2) | 32'($urandom_range(0, 3));
            else if (kind <= 7) addr = CON | 32'($urandom_range(0, 3));
            else if (kind == 8) addr = 32'h2000_0000 + (32'($urandom_range(0, 255)) << 2);
            else                addr = 32'(MEMW) << 2;
            st = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_req(addr, $urandom, st, rd, e, lat);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(1);
        rand_con = 1'b0;
        con_cmd = 1'b1;
        repeat (30) @(negedge clk);
        check("final_drain", 32'(con_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
